// File: rtl/wb_queue.sv
// In-order write-back queue between a result producer and a register-file write port.
// Define WB_QUEUE_BYPASS_EN to compile the pending-value forwarding logic (outputs tie to 0 otherwise).
module wb_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_rd,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     hold,
  output logic                     reg_write,
  output logic [1:0]               rd,
  output logic [DATA_W-1:0]        write_data,
  input  logic [1:0]               rs1,
  input  logic [1:0]               rs2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]        rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push, pop;

  assign in_ready  = (count_q < CW'(DEPTH)) && !reset;
  // Reset discards pending entries, so none may reach the register file during it.
  assign reg_write = (count_q != '0) && !hold && !reset;
  assign push      = in_valid && in_ready;
  assign pop       = reg_write;

  assign rd         = (count_q != '0) ? rd_mem_q[rd_ptr_q]   : 2'b00;
  assign write_data = (count_q != '0) ? data_mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity is defined solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= in_rd;
      data_mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef WB_QUEUE_BYPASS_EN
  always_comb begin
    logic [AW-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    // Walk oldest to youngest so the youngest matching entry wins.
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        idx = rd_ptr_q + AW'(i);
        if (rd_mem_q[idx] == rs1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_mem_q[idx];
        end
        if (rd_mem_q[idx] == rs2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_mem_q[idx];
        end
      end
    end
  end
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus a randomized phase,
// checked against a queue model of the pending entries.
module tb_wb_queue;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 16;
`ifdef WB_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, in_valid, in_ready, hold, reg_write;
  logic [1:0]        in_rd, rd, rs1, rs2;
  logic [DATA_W-1:0] in_data, write_data, fwd1_data, fwd2_data;
  logic              fwd1_hit, fwd2_hit;
  logic [1:0]        count;

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .hold(hold), .reg_write(reg_write),
    .rd(rd), .write_data(write_data), .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data),
    .fwd2_data(fwd2_data), .count(count)
  );

  typedef struct packed {
    logic [1:0]        rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t sb[$];
  int checks = 0, failures = 0, nwrites = 0, maxcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs against the model before the edge, then update the model.
  task automatic cyc();
    logic er, ew, h1, h2;
    logic [DATA_W-1:0] d1, d2;
    int mc;
    #1;
    mc = sb.size();
    er = (mc < DEPTH) && !reset;
    ew = (mc != 0) && !hold && !reset;
    chk("in_ready", in_ready, er);
    chk("reg_write", reg_write, ew);
    chk("count", count, mc);
    if (mc != 0) begin
      chk("head_rd", rd, sb[0].rd);
      chk("head_data", write_data, sb[0].data);
    end else begin
      chk("idle_rd", rd, 0);
      chk("idle_data", write_data, 0);
    end
    h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
    foreach (sb[k]) begin
      if (sb[k].rd == rs1) begin h1 = 1'b1; d1 = sb[k].data; end
      if (sb[k].rd == rs2) begin h2 = 1'b1; d2 = sb[k].data; end
    end
    if (!BYP) begin h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0; end
    chk("fwd1_hit", fwd1_hit, h1);
    chk("fwd1_data", fwd1_data, d1);
    chk("fwd2_hit", fwd2_hit, h2);
    chk("fwd2_data", fwd2_data, d2);
    if (reg_write === 1'b1) nwrites++;
    if (int'(count) > maxcnt) maxcnt = int'(count);
    @(posedge clk);
    if (reset) sb.delete();
    else begin
      if (ew) void'(sb.pop_front());
      if (in_valid && er) sb.push_back({in_rd, in_data});
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; hold = 1'b0; in_rd = '0; in_data = '0;
    rs1 = '0; rs2 = '0;
    @(posedge clk); #1;

    // Reset state and acceptance once reset deasserts
    cyc();
    reset = 1'b0;
    #1;
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_count", count, 0);
    cyc();

    // Single push
    in_valid = 1'b1; in_rd = 2'd2; in_data = 16'h1234;
    cyc();
    in_valid = 1'b0;
    #1;
    chk("single_we", reg_write, 1);
    chk("single_rd", rd, 2);
    chk("single_data", write_data, 16'h1234);
    cyc();
    chk("single_cnt", count, 0);

    // Full and back-pressure
    hold = 1'b1; rs1 = 2'd3; rs2 = 2'd1;
    in_valid = 1'b1; in_rd = 2'd1; in_data = 16'h0011;
    cyc();
    in_rd = 2'd3; in_data = 16'h0033;
    cyc();
    in_rd = 2'd0; in_data = 16'h00FF;
    #1;
    chk("full_count", count, 2);
    chk("full_ready", in_ready, 0);
    cyc();
    in_valid = 1'b0;
    cyc();
    hold = 1'b0;
    #1;
    chk("drain1_we", reg_write, 1);
    chk("drain1_data", write_data, 16'h0011);
    cyc();
    chk("drain2_we", reg_write, 1);
    chk("drain2_data", write_data, 16'h0033);
    cyc();
    chk("drain_cnt", count, 0);

    // Streaming push/pop with pointer wrap
    nwrites = 0; maxcnt = 0; hold = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_rd = 2'(i % 4); in_data = DATA_W'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("stream_writes", nwrites, 8);
    chk("stream_maxcnt", maxcnt, 1);

    // Forwarding: youngest matching entry wins
    hold = 1'b1; in_valid = 1'b1; in_rd = 2'd2; in_data = 16'hAAAA;
    cyc();
    in_data = 16'hBBBB;
    cyc();
    in_valid = 1'b0; rs1 = 2'd2; rs2 = 2'd1;
    #1;
    chk("fwd_hit1", fwd1_hit, BYP ? 1 : 0);
    chk("fwd_data1", fwd1_data, BYP ? 32'hBBBB : 0);
    chk("fwd_hit2", fwd2_hit, 0);
    chk("fwd_data2", fwd2_data, 0);
    cyc();

    // Reset while two entries are pending
    reset = 1'b1; in_valid = 1'b1;
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_we", reg_write, 0);
    chk("rst_ready", in_ready, 1);
    hold = 1'b0; nwrites = 0;
    cyc();
    cyc();
    chk("rst_nowrite", nwrites, 0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      hold     = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 19) == 0);
      in_rd    = 2'($urandom_range(0, 3));
      in_data  = DATA_W'($urandom);
      rs1      = 2'($urandom_range(0, 3));
      rs2      = 2'($urandom_range(0, 3));
      cyc();
    end
    reset = 1'b0; hold = 1'b0; in_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("final_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of pending write-back entries (power of two, 2..8).
REQ-002 SHALL have parameter DATA_W, default 16, write-data width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer presents a result.
REQ-006 SHALL have port in_ready  output  1  queue can accept a result this cycle.
REQ-007 SHALL have port in_rd  input  2  destination register index.
REQ-008 SHALL have port in_data  input  DATA_W  result value.
REQ-009 SHALL have port hold  input  1  register-file write port unavailable this cycle.
REQ-010 SHALL have port reg_write  output  1  write enable to the register file.
REQ-011 SHALL have port rd  output  2  register-file write index.
REQ-012 SHALL have port write_data  output  DATA_W  register-file write value.
REQ-013 SHALL have ports rs1, rs2  input  2 each  read indices being issued to the register file.
REQ-014 SHALL have ports fwd1_hit, fwd2_hit  output  1 each, and fwd1_data, fwd2_data  output  DATA_W each  pending-value forwarding results.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of pending entries.

Function
REQ-016 SHALL operate as an in-order FIFO of (rd, data) pairs; a transfer occurs on a rising edge where in_valid && in_ready.
REQ-017 SHALL drive in_ready = (count < DEPTH) && !reset; no acceptance when full, even if a pop occurs the same cycle.
REQ-018 SHALL drive reg_write = (count != 0) && !hold, combinationally.
REQ-019 SHALL drive rd/write_data from the head entry when count != 0, else 0.
REQ-020 SHALL pop the head on each rising edge where reg_write = 1.
REQ-021 SHALL support simultaneous push and pop when not full: count unchanged, order preserved.
REQ-022 SHALL have latency: entry accepted at edge N appears on the write port in cycle N+1 and is written at edge N+1 if hold = 0.
REQ-023 SHALL keep entries while hold = 1; the head remains stable on rd/write_data.
REQ-024 SHALL wrap read/write pointers modulo DEPTH with no loss or duplication.
REQ-025 SHALL write multiple pending entries to the same rd in acceptance order (last accepted is final value).
REQ-026 SHALL ignore in_rd/in_data when no transfer occurs.

Reset
REQ-027 SHALL, on any rising edge with reset = 1, clear pointers and count to 0, discarding all pending entries, including mid-drain.
REQ-028 SHALL present after reset: count = 0, reg_write = 0, rd = 0, write_data = 0, fwd*_hit = 0, fwd*_data = 0, in_ready = 1 once reset deasserts.
REQ-029 SHALL ignore in_valid and hold during reset.

Configuration
REQ-030 SHALL compile forwarding logic only when macro WB_QUEUE_BYPASS_EN is defined.
REQ-031 SHALL, with WB_QUEUE_BYPASS_EN, drive fwdN_hit = 1 when any pending entry has rd == rsN, with fwdN_data = data of the youngest such entry (combinational).
REQ-032 SHALL, without WB_QUEUE_BYPASS_EN, tie fwd1_hit, fwd2_hit, fwd1_data and fwd2_data to 0; ports remain present.

Verification
REQ-033 SHALL cover single push: push (rd=2, data=0x1234) at edge 0, hold = 0 -> cycle 1 reg_write = 1, rd = 2, write_data = 0x1234; count = 0 after edge 1.
REQ-034 SHALL cover full and back-pressure: DEPTH = 2, hold = 1, push (1, 0x0011), (3, 0x0033) -> count = 2, in_ready = 0; third push (0, 0x00FF) not accepted; release hold -> writes 0x0011 then 0x0033 on consecutive edges.
REQ-035 SHALL cover simultaneous push/pop: steady in_valid = 1, hold = 0, 8 pushes with data 0x0000..0x0007 -> 8 in-order writes, count never exceeds 1, pointers wrap.
REQ-036 SHALL cover forwarding with macro: hold = 1, pending (2, 0xAAAA), then (2, 0xBBBB); rs1 = 2, rs2 = 1 -> fwd1_hit = 1, fwd1_data = 0xBBBB, fwd2_hit = 0; without macro, all forwarding outputs = 0.
REQ-037 SHALL cover reset mid-operation: count = 2 with hold = 1, assert reset for one edge -> count = 0, reg_write = 0, no write of the discarded entries, in_ready = 1 next cycle.
